// File: rtl/voice_mix_scheduler.sv
// voice_mix_scheduler: 16-voice sample-memory read scheduler with saturating mixer
// Ports:
//   clk, rst (async, active-high)
//   sample_tick : one-clk pulse per audio sample period, starts a scan
//   trig[15:0]  : level request per voice, rising edge (re)starts a voice
//   mem_en, mem_addr {voice, pos} : registered read strobe/address to sample memory
//   mem_rdata   : unsigned sample, valid one clk after mem_en
//   mix_out, mix_valid : saturated 16-bit mix and its one-clk update pulse
//   active[15:0], busy, overrun (sticky, cleared only by rst)
// Option: define VOICE_SCHED_LOOP_EN so a voice still held by trig wraps instead of stopping.
module voice_mix_scheduler #(
    parameter int SAMPLE_LEN = 40000,
    parameter int POS_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic [15:0]        trig,
    output logic               mem_en,
    output logic [4+POS_W-1:0] mem_addr,
    input  logic [15:0]        mem_rdata,
    output logic [15:0]        mix_out,
    output logic               mix_valid,
    output logic [15:0]        active,
    output logic               busy,
    output logic               overrun
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} state_t;
    localparam logic [POS_W-1:0] LAST = POS_W'(SAMPLE_LEN - 1);
    state_t state, state_n;
    logic [3:0] k, idx;
    logic issue, vld;
    logic [15:0] trig_q, trig_p, rise, keep;
    logic [POS_W-1:0] pos [16];
    logic [19:0] acc, acc_n;
`ifdef VOICE_SCHED_LOOP_EN
    assign keep = trig_q;
`else
    assign keep = '0;
`endif
    // idx is the voice whose read is issued at the coming edge; the read
    // appears on mem_en/mem_addr one clk later while k points at it.
    always_comb begin
        state_n = state;
        issue = 1'b0;
        idx = k + 4'd1;
        case (state)
            IDLE: begin
                idx = 4'd0;
                if (sample_tick) begin
                    state_n = SCAN;
                    issue = 1'b1;
                end
            end
            SCAN: begin
                if (k == 4'd15) state_n = DRAIN;
                else issue = 1'b1;
            end
            DRAIN: state_n = OUT;
            default: state_n = IDLE;
        endcase
        rise = trig_q & ~trig_p;
        acc_n = acc + (vld ? {4'd0, mem_rdata} : 20'd0);
        mix_valid = state == OUT;
        busy = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            vld <= 1'b0;
            trig_q <= '0;
            trig_p <= '0;
            mem_en <= 1'b0;
            mem_addr <= '0;
            acc <= '0;
            mix_out <= '0;
            overrun <= 1'b0;
            active <= '0;
            for (int v = 0; v < 16; v++) pos[v] <= '0;
        end else begin
            state <= state_n;
            trig_q <= trig;
            trig_p <= trig_q;
            vld <= mem_en;
            mem_en <= issue && active[idx];
            if (issue) begin
                k <= idx;
                mem_addr <= {idx, pos[idx]};
            end
            acc <= state == IDLE ? '0 : acc_n;
            // DRAIN edge folds in the final read, so mix_out is fresh during OUT
            if (state == DRAIN) mix_out <= |acc_n[19:16] ? 16'hFFFF : acc_n[15:0];
            if (sample_tick && state != IDLE) overrun <= 1'b1;
            // A trigger edge overrides the scan's advance of the same voice
            for (int v = 0; v < 16; v++) begin
                if (rise[v]) begin
                    active[v] <= 1'b1;
                    pos[v] <= '0;
                end else if (issue && idx == 4'(v) && active[v]) begin
                    if (pos[v] == LAST) begin
                        pos[v] <= '0;
                        active[v] <= keep[v];
                    end else begin
                        pos[v] <= pos[v] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// tb_voice_mix_scheduler: scoreboard bench for voice_mix_scheduler (SAMPLE_LEN=16)
module tb_voice_mix_scheduler;
    logic clk = 1'b0, rst = 1'b1, sample_tick = 1'b0;
    logic [15:0] trig = '0, mem_rdata = '0;
    logic mem_en, mix_valid, busy, overrun;
    logic [19:0] mem_addr;
    logic [15:0] mix_out, active;
    logic [15:0] vval [16];
    int nvec = 0, nmis = 0, cyc = 0, tickc = 0;
    logic [19:0] addrq [$];
    logic [15:0] mixq [$];

    voice_mix_scheduler #(.SAMPLE_LEN(16), .POS_W(16)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .trig(trig),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mix_out(mix_out), .mix_valid(mix_valid), .active(active),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= mem_en ? vval[mem_addr[19:16]] : 16'hDEAD;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (addrq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected read: got %0h expected none", mem_addr);
                end else chk("read addr", 32'(mem_addr), 32'(addrq.pop_front()));
            end
            if (mix_valid) begin
                if (mixq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected mix_valid: got %0h expected none", mix_out);
                end else begin
                    chk("mix_out", 32'(mix_out), 32'(mixq.pop_front()));
                    chk("latency", 32'(cyc - tickc), 32'd18);
                end
            end
        end
    end

    task automatic do_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        tickc = cyc;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (19) @(negedge clk);
    endtask

    task automatic reset_dut();
        chk("addrq drained", 32'(addrq.size()), 32'd0);
        chk("mixq drained", 32'(mixq.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        trig = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        addrq.delete();
        mixq.delete();
    endtask

    initial begin
        for (int v = 0; v < 16; v++) vval[v] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset mix_out", 32'(mix_out), 32'd0);
        chk("reset active", 32'(active), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        // single voice 3
        trig = 16'h0008;
        vval[3] = 16'h0100;
        repeat (3) @(negedge clk);
        chk("active v3", 32'(active), 32'h0008);
        addrq.push_back({4'd3, 16'd0});
        mixq.push_back(16'h0100);
        do_tick();
        addrq.push_back({4'd3, 16'd1});
        mixq.push_back(16'h0100);
        do_tick();
        // all 16 voices: saturating and non-saturating sums
        reset_dut();
        for (int v = 0; v < 16; v++) vval[v] = 16'h2000;
        trig = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("active all", 32'(active), 32'h0000FFFF);
        for (int v = 0; v < 16; v++) addrq.push_back({4'(v), 16'd0});
        mixq.push_back(16'hFFFF);
        do_tick();
        for (int v = 0; v < 16; v++) vval[v] = 16'h0F00;
        for (int v = 0; v < 16; v++) addrq.push_back({4'(v), 16'd1});
        mixq.push_back(16'hF000);
        do_tick();
        // retrigger voice 2 at position 10
        reset_dut();
        vval[2] = 16'h0042;
        trig = 16'h0004;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            addrq.push_back({4'd2, 16'(i)});
            mixq.push_back(16'h0042);
            do_tick();
        end
        trig = '0;
        repeat (3) @(negedge clk);
        chk("active after fall", 32'(active), 32'h0004);
        trig = 16'h0004;
        repeat (3) @(negedge clk);
        addrq.push_back({4'd2, 16'd0});
        mixq.push_back(16'h0042);
        do_tick();
        // end of buffer for voice 0
        reset_dut();
        vval[0] = 16'h0007;
        @(negedge clk);
        trig = 16'h0001;
`ifndef VOICE_SCHED_LOOP_EN
        @(negedge clk);
        trig = '0;
`endif
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            addrq.push_back({4'd0, 16'(i)});
            mixq.push_back(16'h0007);
            do_tick();
        end
`ifdef VOICE_SCHED_LOOP_EN
        chk("active at end", 32'(active), 32'h0001);
        addrq.push_back({4'd0, 16'd0});
        mixq.push_back(16'h0007);
`else
        chk("active at end", 32'(active), 32'h0000);
        mixq.push_back(16'h0000);
`endif
        do_tick();
        // tick while busy
        reset_dut();
        vval[5] = 16'h0123;
        trig = 16'h0020;
        repeat (3) @(negedge clk);
        chk("overrun before", 32'(overrun), 32'd0);
        addrq.push_back({4'd5, 16'd0});
        mixq.push_back(16'h0123);
        @(negedge clk);
        sample_tick = 1'b1;
        tickc = cyc;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (20) @(negedge clk);
        chk("overrun set", 32'(overrun), 32'd1);
        addrq.push_back({4'd5, 16'd1});
        mixq.push_back(16'h0123);
        do_tick();
        // reset in the middle of a scan
        addrq.push_back({4'd5, 16'd2});
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy mid-scan", 32'(busy), 32'd1);
        rst = 1'b1;
        trig = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort mix_out", 32'(mix_out), 32'd0);
        chk("abort active", 32'(active), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort overrun", 32'(overrun), 32'd0);
        repeat (25) @(negedge clk);
        chk("final addrq", 32'(addrq.size()), 32'd0);
        chk("final mixq", 32'(mixq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
